seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_bus_regs.sv | 72 +++++++
 rtl/seg7_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Register map offsets, control-bit positions and the scan state encoding.
package seg7_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

    localparam logic [7:0] REG_DIG01 = 8'd0;
    localparam logic [7:0] REG_DIG23 = 8'd1;
    localparam logic [7:0] REG_CTRL  = 8'd2;

    localparam int ENABLE_BIT = 4;
    localparam int DOT_LSB    = 0;

    // Pick nibble idx out of four packed digits.
    function automatic logic [3:0] nib_sel(input logic [15:0] v, input logic [1:0] idx);
        return v[idx*4 +: 4];
    endfunction

endpackage

// File: rtl/seg7_bus_regs.sv
// Bus-facing shadow registers for the display: address decode, writes,
// and a registered read response one cycle after the read strobe.
module seg7_bus_regs
    import seg7_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hD0
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [7:0]  addr_i,
    input  logic [7:0]  wdata_i,
    input  logic        we_i,
    input  logic        re_i,
    output logic [7:0]  rdata_o,
    output logic        rvalid_o,
    output logic [15:0] digits_o,
    output logic [3:0]  dots_o,
    output logic        enable_o
);

    logic [7:0] off;
    logic       hit;
    logic [7:0] rd_mux;

    logic [7:0] dig01_q;
    logic [7:0] dig23_q;
    logic [4:0] ctrl_q;
    logic [7:0] rdata_q;
    logic       rvalid_q;

    // Subtraction wraps, so addresses below the base never alias a register.
    assign off = addr_i - BASE_ADDR;
    assign hit = (off <= REG_CTRL);

    always_comb begin
        rd_mux = 8'h00;
        case (off)
            REG_DIG01: rd_mux = dig01_q;
            REG_DIG23: rd_mux = dig23_q;
            REG_CTRL:  rd_mux = {3'b000, ctrl_q};
            default:   rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            dig01_q  <= 8'h00;
            dig23_q  <= 8'h00;
            ctrl_q   <= 5'h00;
            rdata_q  <= 8'h00;
            rvalid_q <= 1'b0;
        end else begin
            if (we_i && hit) begin
                case (off)
                    REG_DIG01: dig01_q <= wdata_i;
                    REG_DIG23: dig23_q <= wdata_i;
                    REG_CTRL:  ctrl_q  <= wdata_i[ENABLE_BIT:DOT_LSB];
                    default:   ;
                endcase
            end
            rvalid_q <= re_i && hit;
            rdata_q  <= (re_i && hit) ? rd_mux : 8'h00;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign digits_o = {dig23_q, dig01_q};
    assign dots_o   = ctrl_q[DOT_LSB +: 4];
    assign enable_o = ctrl_q[ENABLE_BIT];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit seven-segment scanner: commits shadow values at frame boundaries
// and time-multiplexes them onto the decoder with a blank lead-in per slot.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hD0,
    parameter int         SCAN_DIV  = 100000,
    parameter int         BLANK_CYC = 16,
    parameter int         CNT_W     = 17
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic [7:0] bus_addr,
    input  logic [7:0] bus_wdata,
    input  logic       bus_we,
    input  logic       bus_re,
    output logic [7:0] bus_rdata,
    output logic       bus_rvalid,
    output logic [1:0] seg_select_out,
    output logic [3:0] bin_out,
    output logic       dot_out,
    output logic       blank_out,
    output logic       frame_tick
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    logic [15:0] sh_digits;
    logic [3:0]  sh_dots;
    logic        sh_enable;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dig_q, dig_d;
    logic             commit;

    logic [15:0] act_dig_q;
    logic [3:0]  act_dot_q;
    logic [1:0]  sel_q;
    logic [3:0]  bin_q;
    logic        dot_q;
    logic        blank_q;
    logic        tick_q;

    seg7_bus_regs #(
        .BASE_ADDR (BASE_ADDR)
    ) u_regs (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .addr_i   (bus_addr),
        .wdata_i  (bus_wdata),
        .we_i     (bus_we),
        .re_i     (bus_re),
        .rdata_o  (bus_rdata),
        .rvalid_o (bus_rvalid),
        .digits_o (sh_digits),
        .dots_o   (sh_dots),
        .enable_o (sh_enable)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        commit  = 1'b0;
        // Dropping enable wins over every scan transition.
        if (!sh_enable) begin
            state_d = OFF;
            cnt_d   = '0;
            dig_d   = 2'd0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    dig_d   = 2'd0;
                    commit  = 1'b1;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) state_d = SHOW;
                end
                SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        dig_d   = dig_q + 2'd1;
                        state_d = BLANK;
                        commit  = (dig_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = OFF;
                    cnt_d   = '0;
                    dig_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q   <= OFF;
            cnt_q     <= '0;
            dig_q     <= 2'd0;
            act_dig_q <= 16'h0000;
            act_dot_q <= 4'h0;
            sel_q     <= 2'd0;
            bin_q     <= 4'h0;
            dot_q     <= 1'b0;
            blank_q   <= 1'b1;
            tick_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            if (commit) begin
                act_dig_q <= sh_digits;
                act_dot_q <= sh_dots;
            end
            tick_q  <= commit;
            sel_q   <= dig_q;
            bin_q   <= nib_sel(act_dig_q, dig_q);
            dot_q   <= act_dot_q[dig_q];
            blank_q <= (state_q != SHOW);
        end
    end

    assign seg_select_out = sel_q;
    assign bin_out        = bin_q;
    assign dot_out        = dot_q;
    assign blank_out      = blank_q;
    assign frame_tick     = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a short scan (8 cycles/slot, 2 blank).
module tb_seg7_scan_ctrl;

    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_rdata;
    logic       bus_rvalid;
    logic [1:0] seg_select_out;
    logic [3:0] bin_out;
    logic       dot_out;
    logic       blank_out;
    logic       frame_tick;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    logic [8:0] outv;
    assign outv = {frame_tick, blank_out, seg_select_out, bin_out, dot_out};

    always #5 clk_sys = ~clk_sys;

    seg7_scan_ctrl #(
        .BASE_ADDR (8'hD0),
        .SCAN_DIV  (8),
        .BLANK_CYC (2),
        .CNT_W     (3)
    ) dut (
        .clk_sys        (clk_sys),
        .rst_n          (rst_n),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_we         (bus_we),
        .bus_re         (bus_re),
        .bus_rdata      (bus_rdata),
        .bus_rvalid     (bus_rvalid),
        .seg_select_out (seg_select_out),
        .bin_out        (bin_out),
        .dot_out        (dot_out),
        .blank_out      (blank_out),
        .frame_tick     (frame_tick)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = 1'b1;
        step(1);
        bus_we    = 1'b0;
        $display("write addr=%02h data=%02h", a, d);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic rv, output logic [7:0] rd);
        bus_addr = a;
        bus_re   = 1'b1;
        step(1);
        bus_re   = 1'b0;
        rv = bus_rvalid;
        rd = bus_rdata;
        $display("read  addr=%02h rvalid=%0b rdata=%02h", a, rv, rd);
    endtask

    task automatic bus_rw(input logic [7:0] a, input logic [7:0] d, output logic rv, output logic [7:0] rd);
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = 1'b1;
        bus_re    = 1'b1;
        step(1);
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        rv = bus_rvalid;
        rd = bus_rdata;
        $display("rw    addr=%02h wdata=%02h rvalid=%0b rdata=%02h", a, d, rv, rd);
    endtask

    task automatic wait_for(input logic [1:0] sel, input logic blk, input string tag);
        int n = 0;
        while (!(seg_select_out == sel && blank_out == blk) && n < 100) begin
            step(1);
            n++;
        end
        chk(tag, {13'd0, blank_out, seg_select_out}, {13'd0, blk, sel});
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        while (frame_tick !== 1'b1 && n < 100) begin
            step(1);
            n++;
        end
        chk(tag, {15'd0, frame_tick}, 16'd1);
    endtask

    initial begin
        logic       rv;
        logic [7:0] rd;
        logic       seen_tick;
        logic       seen_show;
        logic [3:0] exp_bin [4];
        logic       exp_dot [4];
        logic [8:0] exp_v;

        exp_bin = '{4'h0, 4'h8, 4'hA, 4'hC};
        exp_dot = '{1'b0, 1'b1, 1'b0, 1'b1};

        rst_n     = 1'b0;
        bus_addr  = 8'h00;
        bus_wdata = 8'h00;
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        step(3);
        chk("reset_outputs", {7'd0, outv}, 16'h0080);
        chk("reset_rvalid", {15'd0, bus_rvalid}, 16'd0);
        chk("reset_rdata", {8'd0, bus_rdata}, 16'd0);
        rst_n = 1'b1;

        // Idle with enable=0: stays blank, never ticks.
        seen_tick = 1'b0;
        seen_show = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (frame_tick) seen_tick = 1'b1;
            if (!blank_out) seen_show = 1'b1;
        end
        chk("idle_no_tick", {15'd0, seen_tick}, 16'd0);
        chk("idle_no_show", {15'd0, seen_show}, 16'd0);
        chk("idle_outputs", {7'd0, outv}, 16'h0080);

        // Out-of-window writes must not land anywhere.
        bus_write(8'hD3, 8'hFF);
        bus_write(8'hCF, 8'hFF);
        bus_read(8'hD2, rv, rd);
        chk("miss_wr_rvalid", {15'd0, rv}, 16'd1);
        chk("miss_wr_ctrl", {8'd0, rd}, 16'h0000);
        bus_read(8'hD0, rv, rd);
        chk("miss_wr_dig01", {8'd0, rd}, 16'h0000);

        // Start scanning.
        bus_write(8'hD0, 8'h80);
        bus_write(8'hD1, 8'hCA);
        bus_write(8'hD2, 8'h1A);
        step(1);
        chk("start_tick", {7'd0, outv}, 16'h0080 | 16'h0100);
        for (int j = 0; j < 32; j++) begin
            step(1);
            exp_v = {(j == 31), ((j % 8) < 2), 2'(j / 8), exp_bin[j / 8], exp_dot[j / 8]};
            chk($sformatf("scan_j%0d", j), {7'd0, outv}, {7'd0, exp_v});
        end

        // Register read-back.
        bus_read(8'hD1, rv, rd);
        chk("rd_d1_rvalid", {15'd0, rv}, 16'd1);
        chk("rd_d1_data", {8'd0, rd}, 16'h00CA);
        step(1);
        chk("rd_rvalid_pulse", {15'd0, bus_rvalid}, 16'd0);
        bus_read(8'hD2, rv, rd);
        chk("rd_d2_data", {8'd0, rd}, 16'h001A);
        bus_read(8'hD3, rv, rd);
        chk("rd_miss_rvalid", {15'd0, rv}, 16'd0);
        chk("rd_miss_data", {8'd0, rd}, 16'h0000);

        // Shadow update mid-frame; also same-cycle read returns old value.
        wait_for(2'd1, 1'b0, "s3_reach_d1");
        bus_rw(8'hD0, 8'h55, rv, rd);
        chk("rw_old_value", {8'd0, rd}, 16'h0080);
        chk("s3_d1_still_old", {12'd0, bin_out}, 16'h8);
        wait_for(2'd2, 1'b0, "s3_reach_d2");
        chk("s3_d2_old", {12'd0, bin_out}, 16'hA);
        wait_for(2'd3, 1'b0, "s3_reach_d3");
        chk("s3_d3_old", {11'd0, bin_out, dot_out}, {11'd0, 4'hC, 1'b1});
        wait_tick("s3_tick");
        wait_for(2'd0, 1'b0, "s3_reach_d0");
        chk("s3_d0_new", {11'd0, bin_out, dot_out}, {11'd0, 4'h5, 1'b0});
        wait_for(2'd1, 1'b0, "s3_reach_d1b");
        chk("s3_d1_new", {11'd0, bin_out, dot_out}, {11'd0, 4'h5, 1'b1});

        // Disable mid-SHOW, then re-enable.
        bus_write(8'hD2, 8'h00);
        step(2);
        chk("dis_blank", {14'd0, blank_out, 1'b0}, {14'd0, 1'b1, 1'b0});
        chk("dis_sel", {14'd0, seg_select_out}, 16'd0);
        seen_tick = 1'b0;
        seen_show = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (frame_tick) seen_tick = 1'b1;
            if (!blank_out) seen_show = 1'b1;
        end
        chk("dis_stays_off", {14'd0, seen_tick, seen_show}, 16'd0);
        bus_write(8'hD2, 8'h10);
        step(1);
        chk("reen_tick", {15'd0, frame_tick}, 16'd1);
        step(1);
        chk("reen_first_slot", {7'd0, outv}, {7'd0, 1'b0, 1'b1, 2'd0, 4'h5, 1'b0});
        wait_for(2'd1, 1'b0, "reen_reach_d1");
        chk("reen_d1", {11'd0, bin_out, dot_out}, {11'd0, 4'h5, 1'b0});

        // Reset pulse mid-scan.
        wait_for(2'd2, 1'b0, "s6_reach_d2");
        rst_n = 1'b0;
        step(1);
        chk("midrst_outputs", {7'd0, outv}, 16'h0080);
        chk("midrst_bus", {7'd0, bus_rvalid, bus_rdata}, 16'd0);
        rst_n = 1'b1;
        bus_read(8'hD2, rv, rd);
        chk("midrst_rd_d2", {7'd0, rv, rd}, 16'h0100);
        bus_read(8'hD1, rv, rd);
        chk("midrst_rd_d1", {8'd0, rd}, 16'h0000);

        // Upper control bits are dropped, so this leaves enable low.
        bus_write(8'hD2, 8'hE0);
        bus_read(8'hD2, rv, rd);
        chk("ctrl_hi_dropped", {8'd0, rd}, 16'h0000);
        step(5);
        chk("ctrl_hi_still_off", {7'd0, outv}, 16'h0080);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
